// File: rtl/pic_move_ctrl.sv
// pic_move_ctrl: per-frame bounce motion and ROM read control for a 100x100 picture on a 640x480 field
//   vga_clk, sys_rst       : pixel clock, synchronous active-high reset
//   pix_x, pix_y           : current pixel from the VGA timing generator
//   run_en                 : animate while high; stop is taken at a frame boundary
//   cfg_vld/cfg_rdy        : step handshake, cfg_step_x/y in pixels per frame (0 stored as 1)
//   x_move, y_move, x_dir, y_dir : picture top-left corner and travel direction
//   frame_end, bounce      : one-cycle pulses after the last active pixel of a frame
//   rd_en, rom_addr, pic_valid : picture ROM read strobe, address, and data-valid select
//   PIC_BOUNCE_CNT_EN      : when defined, adds bounce_cnt (saturating count of axis hits)
module pic_move_ctrl #(
    parameter int H_VALID  = 640,
    parameter int V_VALID  = 480,
    parameter int H_PIC    = 100,
    parameter int V_PIC    = 100,
    parameter int PIC_SIZE = 10000
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        run_en,
    input  logic        cfg_vld,
    input  logic [3:0]  cfg_step_x,
    input  logic [3:0]  cfg_step_y,
    output logic        cfg_rdy,
    output logic [9:0]  x_move,
    output logic [9:0]  y_move,
    output logic        x_dir,
    output logic        y_dir,
    output logic        frame_end,
    output logic        bounce,
    output logic        rd_en,
    output logic [13:0] rom_addr,
    output logic        pic_valid
`ifdef PIC_BOUNCE_CNT_EN
    ,
    output logic [15:0] bounce_cnt
`endif
);
    localparam logic [10:0] X_MAX = 11'(H_VALID - H_PIC);
    localparam logic [10:0] Y_MAX = 11'(V_VALID - V_PIC);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [3:0] step_x, step_y;
    logic frame_tick, upd, cfg_acc, x_hit, y_hit;
    logic [10:0] x_sum, y_sum;
    logic [9:0] x_nxt, y_nxt;

    assign frame_tick = pix_x == 10'(H_VALID - 1) && pix_y == 10'(V_VALID - 1);
    assign upd = frame_tick && state == RUN;
    assign cfg_acc = cfg_vld && cfg_rdy;
    // picture window is never wider than the active area, so no separate active-area test
    assign rd_en = {1'b0, pix_x} >= {1'b0, x_move} && {1'b0, pix_x} < {1'b0, x_move} + 11'(H_PIC) &&
                   {1'b0, pix_y} >= {1'b0, y_move} && {1'b0, pix_y} < {1'b0, y_move} + 11'(V_PIC);

    always_comb begin
        cfg_rdy = state == IDLE;
        state_nxt = frame_tick ? (run_en ? RUN : IDLE) : state;
        // 11-bit sums so x_move+step can never wrap before the edge compare
        x_sum = {1'b0, x_move} + {7'd0, step_x};
        y_sum = {1'b0, y_move} + {7'd0, step_y};
        x_hit = x_dir ? (x_move <= {6'd0, step_x}) : (x_sum >= X_MAX);
        y_hit = y_dir ? (y_move <= {6'd0, step_y}) : (y_sum >= Y_MAX);
        x_nxt = x_dir ? (x_hit ? 10'd0 : x_move - {6'd0, step_x}) : (x_hit ? X_MAX[9:0] : x_sum[9:0]);
        y_nxt = y_dir ? (y_hit ? 10'd0 : y_move - {6'd0, step_y}) : (y_hit ? Y_MAX[9:0] : y_sum[9:0]);
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            x_move    <= '0;
            y_move    <= '0;
            x_dir     <= 1'b0;
            y_dir     <= 1'b0;
            step_x    <= 4'd1;
            step_y    <= 4'd1;
            frame_end <= 1'b0;
            bounce    <= 1'b0;
            rom_addr  <= '0;
            pic_valid <= 1'b0;
        end else begin
            frame_end <= frame_tick;
            bounce    <= upd && (x_hit || y_hit);
            pic_valid <= rd_en;
            if (cfg_acc) begin
                step_x <= cfg_step_x == 4'd0 ? 4'd1 : cfg_step_x;
                step_y <= cfg_step_y == 4'd0 ? 4'd1 : cfg_step_y;
            end
            if (upd) begin
                x_move <= x_nxt;
                y_move <= y_nxt;
                x_dir  <= x_dir ^ x_hit;
                y_dir  <= y_dir ^ y_hit;
            end
            // resync at every frame so a glitched count cannot persist
            if (frame_tick)
                rom_addr <= '0;
            else if (rd_en)
                rom_addr <= rom_addr == 14'(PIC_SIZE - 1) ? 14'd0 : rom_addr + 14'd1;
        end
    end

`ifdef PIC_BOUNCE_CNT_EN
    logic [16:0] cnt_sum;
    assign cnt_sum = {1'b0, bounce_cnt} + 17'(x_hit) + 17'(y_hit);

    always_ff @(posedge vga_clk) begin
        if (sys_rst || cfg_acc)
            bounce_cnt <= '0;
        else if (upd)
            bounce_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_pic_move_ctrl.sv
// tb_pic_move_ctrl: directed scoreboard bench for pic_move_ctrl
module tb_pic_move_ctrl;
  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [9:0]  pix_x = 10'd700;
  logic [9:0]  pix_y = 10'd500;
  logic        run_en = 1'b0;
  logic        cfg_vld = 1'b0;
  logic [3:0]  cfg_step_x = 4'd0;
  logic [3:0]  cfg_step_y = 4'd0;
  logic        cfg_rdy, x_dir, y_dir, frame_end, bounce, rd_en, pic_valid;
  logic [9:0]  x_move, y_move;
  logic [13:0] rom_addr;
`ifdef PIC_BOUNCE_CNT_EN
  logic [15:0] bounce_cnt;
`endif
  pic_move_ctrl dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
    .run_en(run_en), .cfg_vld(cfg_vld), .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
    .cfg_rdy(cfg_rdy), .x_move(x_move), .y_move(y_move), .x_dir(x_dir), .y_dir(y_dir),
    .frame_end(frame_end), .bounce(bounce), .rd_en(rd_en), .rom_addr(rom_addr),
    .pic_valid(pic_valid)
`ifdef PIC_BOUNCE_CNT_EN
    , .bounce_cnt(bounce_cnt)
`endif
  );
  always #5 vga_clk = ~vga_clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  typedef struct {
    int x;
    int y;
    bit xd;
    bit yd;
    bit b;
    bit rdy;
    int cnt;
  } exp_t;
  exp_t q[$];
  int mx, my, msx, msy, mcnt;
  bit mdx, mdy, mrun;
  task automatic model_reset();
    mx = 0; my = 0; mdx = 0; mdy = 0; msx = 1; msy = 1; mcnt = 0; mrun = 0;
  endtask
  task automatic axis(inout int p, inout bit d, input int s, input int lim, output bit h);
    h = 0;
    if (d == 0) begin
      if (p + s >= lim) begin p = lim; d = 1; h = 1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 0; h = 1; end
      else p = p - s;
    end
  endtask
  task automatic frame();
    exp_t e;
    bit hx, hy;
    int cyc;
    hx = 0; hy = 0;
    if (mrun) begin
      axis(mx, mdx, msx, 540, hx);
      axis(my, mdy, msy, 380, hy);
    end
    mcnt = mcnt + int'(hx) + int'(hy);
    if (mcnt > 65535) mcnt = 65535;
    mrun = run_en;
    e.x = mx; e.y = my; e.xd = mdx; e.yd = mdy; e.b = hx | hy; e.rdy = !mrun; e.cnt = mcnt;
    q.push_back(e);
    @(negedge vga_clk);
    pix_x = 10'd639; pix_y = 10'd479;
    @(negedge vga_clk);
    pix_x = 10'd700; pix_y = 10'd500;
    cyc = 0;
    while (!frame_end && cyc < 4) begin
      @(negedge vga_clk);
      cyc++;
    end
    chk("frame_end_seen", frame_end, 1'b1);
    e = q.pop_front();
    if (frame_end) begin
      chk("x_move", x_move, e.x);
      chk("y_move", y_move, e.y);
      chk("x_dir", x_dir, e.xd);
      chk("y_dir", y_dir, e.yd);
      chk("bounce", bounce, e.b);
      chk("cfg_rdy_frame", cfg_rdy, e.rdy);
      chk("rom_addr_frame", rom_addr, 0);
`ifdef PIC_BOUNCE_CNT_EN
      chk("bounce_cnt", bounce_cnt, e.cnt);
`endif
    end
    @(negedge vga_clk);
    chk("frame_end_width", frame_end, 1'b0);
    chk("bounce_width", bounce, 1'b0);
  endtask
  task automatic cfg(input int sx, input int sy);
    @(negedge vga_clk);
    cfg_vld = 1'b1; cfg_step_x = 4'(sx); cfg_step_y = 4'(sy);
    chk("cfg_rdy", cfg_rdy, !mrun);
    if (!mrun) begin
      msx = sx == 0 ? 1 : sx;
      msy = sy == 0 ? 1 : sy;
      mcnt = 0;
    end
    @(negedge vga_clk);
    cfg_vld = 1'b0;
  endtask
  task automatic check_reset_state(input bit with_pv);
    chk("rst_x_move", x_move, 0);
    chk("rst_y_move", y_move, 0);
    chk("rst_x_dir", x_dir, 1'b0);
    chk("rst_y_dir", y_dir, 1'b0);
    chk("rst_frame_end", frame_end, 1'b0);
    chk("rst_bounce", bounce, 1'b0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_cfg_rdy", cfg_rdy, 1'b1);
    if (with_pv) chk("rst_pic_valid", pic_valid, 1'b0);
`ifdef PIC_BOUNCE_CNT_EN
    chk("rst_bounce_cnt", bounce_cnt, 0);
`endif
  endtask
  initial begin
    int k;
    model_reset();
    repeat (3) @(negedge vga_clk);
    sys_rst = 1'b0;
    check_reset_state(1'b1);
    repeat (3) frame();
    cfg(5, 0);
    run_en = 1'b1;
    frame();
    frame();
    chk("dir_x5", x_move, 5);
    chk("dir_y1", y_move, 1);
    frame();
    frame();
    cfg(15, 15);
    repeat (103) frame();
    chk("dir_x530", x_move, 530);
    run_en = 1'b0;
    frame();
    chk("dir_x535", x_move, 535);
    chk("dir_idle_rdy", cfg_rdy, 1'b1);
    frame();
    cfg(7, 1);
    run_en = 1'b1;
    frame();
    frame();
    chk("dir_x540", x_move, 540);
    chk("dir_xdir1", x_dir, 1'b1);
    frame();
    chk("dir_x533", x_move, 533);
    chk("dir_y109", y_move, 109);
    @(negedge vga_clk);
    pix_x = 10'd540; pix_y = 10'd150;
    @(negedge vga_clk);
    chk("pre_rst_pic_valid", pic_valid, 1'b1);
    sys_rst = 1'b1;
    @(negedge vga_clk);
    sys_rst = 1'b0;
    pix_x = 10'd700; pix_y = 10'd500;
    model_reset();
    check_reset_state(1'b1);
    cfg(10, 5);
    frame();
    repeat (19) frame();
    run_en = 1'b0;
    frame();
    chk("dir_x200", x_move, 200);
    chk("dir_y100", y_move, 100);
    @(negedge vga_clk); pix_x = 10'd199; pix_y = 10'd100; #1 chk("rd_left", rd_en, 1'b0);
    @(negedge vga_clk); pix_x = 10'd200; pix_y = 10'd99;  #1 chk("rd_top", rd_en, 1'b0);
    @(negedge vga_clk); pix_x = 10'd200; pix_y = 10'd100; #1 chk("rd_first", rd_en, 1'b1);
    @(negedge vga_clk); pix_x = 10'd300; pix_y = 10'd100; #1 chk("rd_right", rd_en, 1'b0);
    chk("pic_valid_lag", pic_valid, 1'b1);
    @(negedge vga_clk); pix_x = 10'd299; pix_y = 10'd199; #1 chk("rd_last", rd_en, 1'b1);
    chk("pic_valid_off", pic_valid, 1'b0);
    @(negedge vga_clk); pix_x = 10'd200; pix_y = 10'd200; #1 chk("rd_bottom", rd_en, 1'b0);
    chk("rom_two_reads", rom_addr, 2);
    frame();
    k = 0;
    for (int r = 100; r < 200; r++) begin
      for (int c = 200; c < 300; c++) begin
        @(negedge vga_clk);
        if (k == 1) chk("rom_addr_1", rom_addr, 1);
        if (k == 9999) chk("rom_addr_9999", rom_addr, 9999);
        pix_x = 10'(c); pix_y = 10'(r);
        k++;
      end
    end
    @(negedge vga_clk);
    pix_x = 10'd700; pix_y = 10'd500;
    chk("rom_addr_wrap", rom_addr, 0);
    frame();
    cfg(15, 5);
    run_en = 1'b1;
    frame();
    repeat (11) frame();
    run_en = 1'b0;
    frame();
    chk("dir_x380", x_move, 380);
    chk("dir_y160", y_move, 160);
    cfg(10, 14);
    run_en = 1'b1;
    frame();
    repeat (15) frame();
    run_en = 1'b0;
    frame();
    chk("corner_hi_x", x_move, 540);
    chk("corner_hi_y", y_move, 380);
    chk("corner_hi_yd", y_dir, 1'b1);
    cfg(15, 10);
    run_en = 1'b1;
    frame();
    repeat (34) frame();
    run_en = 1'b0;
    frame();
    chk("dir_x15", x_move, 15);
    chk("dir_y30", y_move, 30);
    cfg(12, 15);
    run_en = 1'b1;
    frame();
    run_en = 1'b0;
    frame();
    chk("dir_x3", x_move, 3);
    chk("dir_y15", y_move, 15);
    cfg(4, 15);
    run_en = 1'b1;
    frame();
    run_en = 1'b0;
    frame();
    chk("corner_lo_x", x_move, 0);
    chk("corner_lo_y", y_move, 0);
    chk("corner_lo_xd", x_dir, 1'b0);
    chk("corner_lo_yd", y_dir, 1'b0);
`ifdef PIC_BOUNCE_CNT_EN
    chk("corner_lo_cnt", bounce_cnt, 2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
